temp_sensor_reader: RTL and testbench

- Upstream stage of the thermostat top. Polls an external serial temperature sensor on a 3-wire interface (cs_n, sclk, sdi).
- Converts each 8-bit reading to the 5-bit temperature bus consumed by the heating/cooling controller.
- Optionally smooths readings with a 4-tap moving average so the controller does not chatter near its thresholds.

---
 rtl/temp_sensor_reader.sv | 175 +++++++++++++++++
 tb/tb_temp_sensor_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sensor_reader.sv
// temp_sensor_reader: polls a 3-wire serial temperature sensor and publishes a saturated 5-bit reading.
// Define TEMP_AVG_FILTER_EN to smooth readings with a 4-tap moving average.
module temp_sensor_reader #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned SAMPLE_GAP = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdi,
  output logic       cs_n,
  output logic       sclk,
  output logic [4:0] temperature,
  output logic       temp_valid,
  output logic       sensor_fault
);

  // state | meaning
  // IDLE  | cs_n high, counting the inter-frame gap
  // SETUP | cs_n low, sclk low for one half-period before the first rising edge
  // SHIFT | eight sclk periods, sdi captured on each rising sclk
  // DONE  | cs_n high, frame evaluated; result published on the exit edge
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE} state_t;

  localparam logic [15:0] GAP_LAST = 16'(SAMPLE_GAP - 1);
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0]  TEMP_RST = 5'd20;

  state_t      state_q, state_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic [4:0]  temp_q, temp_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [4:0]  sample_sat;
  logic [4:0]  filtered;

  assign sample_sat = (shift_q > 8'd31) ? 5'd31 : shift_q[4:0];

`ifdef TEMP_AVG_FILTER_EN
  logic [3:0][4:0] hist_q, hist_d, hist_shift;
  logic            hist_vld_q, hist_vld_d;
  logic [6:0]      hist_sum;

  // An empty history is primed with the first sample so the first output equals it.
  always_comb begin
    if (hist_vld_q) hist_shift = {hist_q[2:0], sample_sat};
    else            hist_shift = {4{sample_sat}};
    hist_sum = 7'(hist_shift[0]) + 7'(hist_shift[1]) + 7'(hist_shift[2]) + 7'(hist_shift[3]);
    filtered = 5'(hist_sum >> 2);
  end
`else
  assign filtered = sample_sat;
`endif

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    temp_d  = temp_q;
    valid_d = 1'b0;
    fault_d = fault_q;
`ifdef TEMP_AVG_FILTER_EN
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
`endif
    case (state_q)
      S_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          div_d   = DIV_LAST;
          cs_n_d  = 1'b0;
          state_d = S_SETUP;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      S_SETUP: begin
        if (div_q == '0) begin
          div_d   = DIV_LAST;
          bit_d   = '0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_SHIFT: begin
        if (div_q == '0) begin
          div_d = DIV_LAST;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shift_d = {shift_q[6:0], sdi};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 3'd7) begin
              cs_n_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_DONE: begin
        gap_d   = '0;
        state_d = S_IDLE;
        // An all-ones frame means the sensor is absent or the line is stuck high.
        if (shift_q == 8'hFF) begin
          fault_d = 1'b1;
        end else begin
          temp_d  = filtered;
          valid_d = 1'b1;
`ifdef TEMP_AVG_FILTER_EN
          hist_d     = hist_shift;
          hist_vld_d = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      temp_q  <= TEMP_RST;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
`ifdef TEMP_AVG_FILTER_EN
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
`ifdef TEMP_AVG_FILTER_EN
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
`endif
    end
  end

  assign cs_n         = cs_n_q;
  assign sclk         = sclk_q;
  assign temperature  = temp_q;
  assign temp_valid   = valid_q;
  assign sensor_fault = fault_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Testbench for temp_sensor_reader: serial sensor model, frame monitor and a queue-based reference model.
module tb_temp_sensor_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sdi = 1'b0;
  logic       cs_n, sclk, temp_valid, sensor_fault;
  logic [4:0] temperature;

  always #5 clk = ~clk;

  temp_sensor_reader #(.CLK_DIV(4), .SAMPLE_GAP(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sdi          (sdi),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .temperature  (temperature),
    .temp_valid   (temp_valid),
    .sensor_fault (sensor_fault)
  );

  int tests = 0;
  int failed = 0;

  logic [7:0] tx_byte = 8'd0;

  // Monitor state, written only by the monitor process.
  int edge_cnt = 0, cs_fall_edge = 0, cs_fall_prev = 0, cs_rise_edge = 0, frames_done = 0;
  int frame_rises = 0, last_frame_rises = 0, first_rise_off = 0, last_rise_edge = 0, spacing_bad = 0;
  int pulse_cnt = 0, pulse_edge = 0, temp_glitch = 0, bit_idx = 0;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [4:0] prev_temp = 5'd20;

  always @(posedge clk) begin
    logic sclk_rose;
    #2;
    edge_cnt++;
    sclk_rose = (prev_sclk === 1'b0) && (sclk === 1'b1);
    if (rst_n === 1'b1) begin
      if (prev_cs === 1'b1 && cs_n === 1'b0) begin
        cs_fall_prev = cs_fall_edge;
        cs_fall_edge = edge_cnt;
        frame_rises  = 0;
      end
      if (prev_cs === 1'b0 && cs_n === 1'b1) begin
        cs_rise_edge     = edge_cnt;
        frames_done++;
        last_frame_rises = frame_rises;
      end
      if (sclk_rose) begin
        if (frame_rises == 0) first_rise_off = edge_cnt - cs_fall_edge;
        else if (edge_cnt - last_rise_edge != 8) spacing_bad++;
        frame_rises++;
        last_rise_edge = edge_cnt;
      end
      if (temp_valid === 1'b1) begin
        pulse_cnt++;
        pulse_edge = edge_cnt;
      end else if (temperature !== prev_temp) begin
        temp_glitch++;
      end
    end
    // Sensor: presents the next bit after every rising sclk, MSB first.
    if (cs_n !== 1'b0) bit_idx = 0;
    else if (sclk_rose) bit_idx++;
    sdi = (cs_n === 1'b0 && bit_idx < 8) ? tx_byte[3'(7 - bit_idx)] : 1'b0;
    prev_cs   = cs_n;
    prev_sclk = sclk;
    prev_temp = temperature;
  end

  // Reference model: list of accepted samples, newest first.
  int ref_temp = 20;
  int ref_fault = 0;
  int hist[$];

  function automatic void ref_reset();
    ref_temp  = 20;
    ref_fault = 0;
    hist.delete();
  endfunction

  function automatic int ref_frame(input int raw);
    int s;
    if (raw == 255) begin
      ref_fault = 1;
      return 0;
    end
    s = (raw > 31) ? 31 : raw;
`ifdef TEMP_AVG_FILTER_EN
    begin
      int sum;
      if (hist.size() == 0) hist = '{s, s, s, s};
      else begin
        hist.push_front(s);
        void'(hist.pop_back());
      end
      sum = 0;
      foreach (hist[i]) sum += hist[i];
      ref_temp = sum / 4;
    end
`else
    hist.push_front(s);
    ref_temp = s;
`endif
    return 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(output int rel);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {cs_n, sclk, temperature, temp_valid, sensor_fault},
          {1'b1, 1'b0, 5'd20, 1'b0, 1'b0});
    rst_n = 1'b1;
    rel = edge_cnt;
    ref_reset();
  endtask

  task automatic run_frame(input logic [7:0] tx, output int pulses);
    int  base_frames, base_pulses;
    bit  done;
    tx_byte     = tx;
    base_frames = frames_done;
    base_pulses = pulse_cnt;
    done        = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (frames_done != base_frames) done = 1'b1;
    end
    check("frame_complete", 32'(done), 32'd1);
    repeat (2) @(negedge clk);
    pulses = pulse_cnt - base_pulses;
  endtask

  task automatic apply(input logic [7:0] tx, input bit chk_period, input string tag, output int pulses);
    int exp_pulses;
    run_frame(tx, pulses);
    exp_pulses = ref_frame(int'(tx));
    check({tag, "_pulses"}, pulses, exp_pulses);
    check({tag, "_temp"}, 32'(temperature), ref_temp);
    check({tag, "_fault"}, 32'(sensor_fault), ref_fault);
    check({tag, "_sclk_rises"}, last_frame_rises, 8);
    if (chk_period) check({tag, "_period"}, cs_fall_edge - cs_fall_prev, 169);
  endtask

  typedef struct {
    logic [7:0] tx;
    int         exp_pulses;
    int         exp_fault;
  } vec_t;

  vec_t vecs1[$];
  vec_t vecs2[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
    $fatal(1);
  end

  initial begin
    int   bad, rel0, pulses;
    bit   done;
    logic [7:0] rtx;

    vecs1.push_back('{8'd40, 1, 0});
    vecs1.push_back('{8'hFF, 0, 1});
    vecs1.push_back('{8'd18, 1, 1});
    for (int v = 20; v <= 25; v++) vecs1.push_back('{8'(v), 1, 1});
    for (int v = 24; v >= 15; v--) vecs1.push_back('{8'(v), 1, 1});

    vecs2.push_back('{8'd20, 1, 0});
    vecs2.push_back('{8'd24, 1, 0});
    vecs2.push_back('{8'd24, 1, 0});
    vecs2.push_back('{8'd24, 1, 0});
    vecs2.push_back('{8'hFF, 0, 1});

    // Reset, idle window and first frame.
    tx_byte = 8'd23;
    do_reset(rel0);
    bad = 0;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || sclk !== 1'b0 || temperature !== 5'd20 || temp_valid !== 1'b0) bad++;
    end
    check("idle_bad_cycles", bad, 0);
    @(negedge clk);
    check("cs_low_at_clock_100", 32'(cs_n), 32'd0);
    apply(8'd23, 1'b0, "first", pulses);
    check("first_cs_fall_edge", cs_fall_edge - rel0, 100);
    check("first_cs_low_len", cs_rise_edge - cs_fall_edge, 68);
    check("first_rise_offset", first_rise_off, 8);
    check("first_pulse_edge", pulse_edge - cs_rise_edge, 1);

    // Saturation, fault and thermostat sweep.
    foreach (vecs1[i]) begin
      apply(vecs1[i].tx, 1'b1, $sformatf("vec1_%0d", i), pulses);
      check($sformatf("vec1_%0d_tbl_pulses", i), pulses, vecs1[i].exp_pulses);
      check($sformatf("vec1_%0d_tbl_fault", i), 32'(sensor_fault), vecs1[i].exp_fault);
    end

    // Reset one clock after the third sclk rise of a frame.
    tx_byte = 8'd25;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0 && frame_rises == 3) done = 1'b1;
    end
    check("midreset_reach_rise3", 32'(done), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {cs_n, sclk, temperature, temp_valid, sensor_fault},
          {1'b1, 1'b0, 5'd20, 1'b0, 1'b0});
    rst_n = 1'b1;
    rel0 = edge_cnt;
    ref_reset();
    apply(8'd25, 1'b0, "after_reset", pulses);
    check("after_reset_cs_fall", cs_fall_edge - rel0, 100);

    // Random frames against the reference model.
    for (int i = 0; i < 12; i++) begin
      rtx = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rtx = 8'hFF;
      apply(rtx, 1'b1, $sformatf("rand_%0d", i), pulses);
    end

    // Fresh history: 20,24,24,24 then an absent-sensor frame.
    do_reset(rel0);
    foreach (vecs2[i]) begin
      apply(vecs2[i].tx, i > 0, $sformatf("vec2_%0d", i), pulses);
      check($sformatf("vec2_%0d_tbl_pulses", i), pulses, vecs2[i].exp_pulses);
      check($sformatf("vec2_%0d_tbl_fault", i), 32'(sensor_fault), vecs2[i].exp_fault);
    end

    check("sclk_spacing_bad", spacing_bad, 0);
    check("temp_change_without_pulse", temp_glitch, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
